// File: rtl/rv32i_pkg.sv
// Decoded RV32I base-instruction identifiers shared by the core's pipeline blocks.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package rv32i_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } rv32i_base_instr;

endpackage

// File: rtl/lsu_single_cycle.sv
// Load/store unit: one data-memory transaction per memory instruction, with
// byte/half/word lane steering and sign/zero extension.
// Latency: start->done = 3 cycles plus gnt/rvalid wait; misaligned start->done = 1 cycle.
// Backpressure: busy stalls the core; request fields hold until mem_gnt.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start, opcode_e, addr,        instruction from the core (sampled only in IDLE)
//   store_data
//   busy, done, misaligned,       core-side status and extended load result
//   load_data
//   mem_req/we/addr/be/wdata      request to data memory
//   mem_gnt, mem_rvalid,          grant and response from data memory
//   mem_rdata
module lsu_single_cycle
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  rv32i_base_instr         opcode_e,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  output logic                    busy,
  output logic                    done,
  output logic                    misaligned,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  rv32i_base_instr       r_op;
  logic [ADDR_WIDTH-3:0] r_addr_hi;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic                  r_mis;
  logic [DATA_WIDTH-1:0] r_load;

  logic                  w_is_mem;
  logic                  w_mis_in;
  logic                  w_accept;
  logic                  w_is_store;
  logic [BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_ext;

  // Decode of the incoming instruction, used only in the IDLE cycle.
  always_comb begin
    w_is_mem = 1'b0;
    w_mis_in = 1'b0;
    case (opcode_e)
      LB, LBU, SB: w_is_mem = 1'b1;
      LH, LHU, SH: begin
        w_is_mem = 1'b1;
        w_mis_in = addr[0];
      end
      LW, SW: begin
        w_is_mem = 1'b1;
        w_mis_in = |addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_accept = (r_state == IDLE) && start && w_is_mem;

  // Lane steering from the latched instruction.
  always_comb begin
    w_is_store = 1'b0;
    w_be       = '0;
    w_wdata    = '0;
    case (r_op)
      SB: begin
        w_is_store = 1'b1;
        w_be       = {{(BE_W-1){1'b0}}, 1'b1} << r_off;
        w_wdata    = {(DATA_WIDTH/8){r_sdata[7:0]}};
      end
      SH: begin
        w_is_store = 1'b1;
        w_be       = {{(BE_W-2){1'b0}}, 2'b11} << r_off;
        w_wdata    = {(DATA_WIDTH/16){r_sdata[15:0]}};
      end
      SW: begin
        w_is_store = 1'b1;
        w_be       = '1;
        w_wdata    = r_sdata;
      end
      LB, LBU: w_be = {{(BE_W-1){1'b0}}, 1'b1} << r_off;
      LH, LHU: w_be = {{(BE_W-2){1'b0}}, 2'b11} << r_off;
      default: w_be = '1;
    endcase
  end

  // Shift the addressed byte/half down to bit 0, then extend.
  assign w_lane = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_op)
      LB:      w_ext = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      LBU:     w_ext = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
      LH:      w_ext = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      LHU:     w_ext = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= LB;
      r_addr_hi <= '0;
      r_off     <= '0;
      r_sdata   <= '0;
      r_mis     <= 1'b0;
      r_load    <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= opcode_e;
        r_addr_hi <= addr[ADDR_WIDTH-1:2];
        r_off     <= addr[1:0];
        r_sdata   <= store_data;
        r_mis     <= w_mis_in;
      end
      if ((r_state == WAIT) && mem_rvalid && !w_is_store) begin
        r_load <= w_ext;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        busy = w_accept;
        if (w_accept) begin
          w_next = w_mis_in ? RESP : REQ;
        end
      end
      REQ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = w_is_store;
        mem_addr  = {r_addr_hi, 2'b00};
        mem_be    = w_be;
        mem_wdata = w_wdata;
        if (mem_gnt) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          w_next = RESP;
        end
      end
      RESP: begin
        done       = 1'b1;
        misaligned = r_mis;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign load_data = r_load;

endmodule

// File: tb/tb_lsu_single_cycle.sv
// Directed-vector bench for lsu_single_cycle.
// Cycle T is the cycle in which start is driven; outputs are sampled on the falling edge.
// Memory grant/response timing is scheduled relative to T by each scenario.
module tb_lsu_single_cycle;
  import rv32i_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  rv32i_base_instr opcode_e;
  logic [31:0]     addr;
  logic [31:0]     store_data;
  logic            busy;
  logic            done;
  logic            misaligned;
  logic [31:0]     load_data;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;

  always #5 clk = ~clk;

  lsu_single_cycle #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode_e(opcode_e), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .misaligned(misaligned),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_ld = 32'h0;

  // Observations captured by run_access (no checking inside).
  int          o_done_cyc, o_req_cnt, o_busy_cnt;
  logic        o_mis, o_we, o_stable;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;

  // Drive one instruction at cycle T, grant at T+1+gdly, rvalid at T+2+gdly+rdly.
  // Watches at most 16 cycles for done; o_done_cyc stays -1 if none appears.
  task automatic run_access(input rv32i_base_instr op, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int gdly, input int rdly);
    o_done_cyc = -1; o_req_cnt = 0; o_busy_cnt = 0; o_stable = 1'b1; o_mis = 1'b0;
    o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0; o_ld = '0;
    @(posedge clk); #1;
    start = 1'b1; opcode_e = op; addr = a; store_data = sd; mem_rdata = rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if (busy) o_busy_cnt++;
    if (mem_req) o_req_cnt++;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      start      = 1'b0;
      mem_gnt    = (c == 1 + gdly);
      mem_rvalid = (c == 2 + gdly + rdly);
      @(negedge clk);
      if (mem_req) begin
        if (o_req_cnt == 0) begin
          o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        end else if (mem_we !== o_we || mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata) begin
          o_stable = 1'b0;
        end
        o_req_cnt++;
      end
      if (done) begin
        o_done_cyc = c; o_mis = misaligned; o_ld = load_data;
        break;
      end
      if (busy) o_busy_cnt++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; opcode_e = ADD; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b exp 0", done); end
    vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_mis got %0b exp 0", misaligned); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0b exp 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %0b exp 0", mem_we); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    vectors++; if (mem_be !== 4'h0) begin miscompares++; $display("FAIL reset_be got %h exp 0", mem_be); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL reset_ld got %h exp 0", load_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    run_access(SW, 32'h100, 32'hDEADBEEF, 32'h55AA55AA, 0, 0);
    vectors++; if (o_req_cnt !== 1) begin miscompares++; $display("FAIL sw_req_cycles got %0d exp 1", o_req_cnt); end
    vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL sw_we got %0b exp 1", o_we); end
    vectors++; if (o_addr !== 32'h100) begin miscompares++; $display("FAIL sw_addr got %h exp 00000100", o_addr); end
    vectors++; if (o_be !== 4'hF) begin miscompares++; $display("FAIL sw_be got %h exp f", o_be); end
    vectors++; if (o_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata got %h exp deadbeef", o_wdata); end
    vectors++; if (o_done_cyc !== 3) begin miscompares++; $display("FAIL sw_done_cyc got %0d exp 3", o_done_cyc); end
    vectors++; if (o_mis !== 1'b0) begin miscompares++; $display("FAIL sw_mis got %0b exp 0", o_mis); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL sw_ld_held got %h exp %h", o_ld, exp_ld); end
    vectors++; if (o_busy_cnt !== 3) begin miscompares++; $display("FAIL sw_busy_cycles got %0d exp 3", o_busy_cnt); end
  endtask

  task automatic test_byte_loads();
    run_access(LB, 32'h103, 32'hFFFFFFFF, 32'h80FF0000, 0, 0);
    exp_ld = 32'hFFFFFF80;
    vectors++; if (o_be !== 4'h8) begin miscompares++; $display("FAIL lb_be got %h exp 8", o_be); end
    vectors++; if (o_we !== 1'b0) begin miscompares++; $display("FAIL lb_we got %0b exp 0", o_we); end
    vectors++; if (o_wdata !== 32'h0) begin miscompares++; $display("FAIL lb_wdata got %h exp 0", o_wdata); end
    vectors++; if (o_addr !== 32'h100) begin miscompares++; $display("FAIL lb_addr got %h exp 00000100", o_addr); end
    vectors++; if (o_done_cyc !== 3) begin miscompares++; $display("FAIL lb_done_cyc got %0d exp 3", o_done_cyc); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL lb_data got %h exp %h", o_ld, exp_ld); end
    run_access(LBU, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
    exp_ld = 32'h00000080;
    vectors++; if (o_be !== 4'h8) begin miscompares++; $display("FAIL lbu_be got %h exp 8", o_be); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL lbu_data got %h exp %h", o_ld, exp_ld); end
  endtask

  task automatic test_half_loads();
    run_access(LH, 32'h102, 32'h0, 32'h80011234, 0, 0);
    exp_ld = 32'hFFFF8001;
    vectors++; if (o_be !== 4'hC) begin miscompares++; $display("FAIL lh_be got %h exp c", o_be); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL lh_data got %h exp %h", o_ld, exp_ld); end
    run_access(LHU, 32'h102, 32'h0, 32'h80011234, 0, 0);
    exp_ld = 32'h00008001;
    vectors++; if (o_be !== 4'hC) begin miscompares++; $display("FAIL lhu_be got %h exp c", o_be); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL lhu_data got %h exp %h", o_ld, exp_ld); end
  endtask

  task automatic test_sh();
    run_access(SH, 32'h202, 32'h1234ABCD, 32'hA5A5A5A5, 0, 0);
    vectors++; if (o_be !== 4'hC) begin miscompares++; $display("FAIL sh_be got %h exp c", o_be); end
    vectors++; if (o_wdata !== 32'hABCDABCD) begin miscompares++; $display("FAIL sh_wdata got %h exp abcdabcd", o_wdata); end
    vectors++; if (o_addr !== 32'h200) begin miscompares++; $display("FAIL sh_addr got %h exp 00000200", o_addr); end
    vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL sh_we got %0b exp 1", o_we); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL sh_ld_held got %h exp %h", o_ld, exp_ld); end
  endtask

  task automatic test_misaligned();
    run_access(LW, 32'h101, 32'h0, 32'h11111111, 0, 0);
    vectors++; if (o_done_cyc !== 1) begin miscompares++; $display("FAIL mis_lw_done_cyc got %0d exp 1", o_done_cyc); end
    vectors++; if (o_mis !== 1'b1) begin miscompares++; $display("FAIL mis_lw_flag got %0b exp 1", o_mis); end
    vectors++; if (o_req_cnt !== 0) begin miscompares++; $display("FAIL mis_lw_req_cycles got %0d exp 0", o_req_cnt); end
    vectors++; if (o_busy_cnt !== 1) begin miscompares++; $display("FAIL mis_lw_busy_cycles got %0d exp 1", o_busy_cnt); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL mis_lw_ld_held got %h exp %h", o_ld, exp_ld); end
    run_access(SH, 32'h203, 32'h12345678, 32'h0, 0, 0);
    vectors++; if (o_done_cyc !== 1) begin miscompares++; $display("FAIL mis_sh_done_cyc got %0d exp 1", o_done_cyc); end
    vectors++; if (o_mis !== 1'b1) begin miscompares++; $display("FAIL mis_sh_flag got %0b exp 1", o_mis); end
    vectors++; if (o_req_cnt !== 0) begin miscompares++; $display("FAIL mis_sh_req_cycles got %0d exp 0", o_req_cnt); end
    vectors++; if (o_busy_cnt !== 1) begin miscompares++; $display("FAIL mis_sh_busy_cycles got %0d exp 1", o_busy_cnt); end
    // Byte access at an odd address is legal.
    run_access(SB, 32'h203, 32'h000000C3, 32'h0, 0, 0);
    vectors++; if (o_mis !== 1'b0) begin miscompares++; $display("FAIL sb_odd_mis got %0b exp 0", o_mis); end
    vectors++; if (o_be !== 4'h8) begin miscompares++; $display("FAIL sb_odd_be got %h exp 8", o_be); end
    vectors++; if (o_wdata !== 32'hC3C3C3C3) begin miscompares++; $display("FAIL sb_odd_wdata got %h exp c3c3c3c3", o_wdata); end
  endtask

  task automatic test_ignored_opcode();
    run_access(ADD, 32'h100, 32'h0, 32'h0, 0, 0);
    vectors++; if (o_done_cyc !== -1) begin miscompares++; $display("FAIL add_done_cyc got %0d exp -1", o_done_cyc); end
    vectors++; if (o_busy_cnt !== 0) begin miscompares++; $display("FAIL add_busy_cycles got %0d exp 0", o_busy_cnt); end
    vectors++; if (o_req_cnt !== 0) begin miscompares++; $display("FAIL add_req_cycles got %0d exp 0", o_req_cnt); end
  endtask

  task automatic test_rvalid_delay();
    run_access(LW, 32'h44, 32'h0, 32'h13579BDF, 1, 2);
    exp_ld = 32'h13579BDF;
    vectors++; if (o_done_cyc !== 6) begin miscompares++; $display("FAIL lw_dly_done_cyc got %0d exp 6", o_done_cyc); end
    vectors++; if (o_req_cnt !== 2) begin miscompares++; $display("FAIL lw_dly_req_cycles got %0d exp 2", o_req_cnt); end
    vectors++; if (o_stable !== 1'b1) begin miscompares++; $display("FAIL lw_dly_stable got %0b exp 1", o_stable); end
    vectors++; if (o_busy_cnt !== 6) begin miscompares++; $display("FAIL lw_dly_busy_cycles got %0d exp 6", o_busy_cnt); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL lw_dly_data got %h exp %h", o_ld, exp_ld); end
  endtask

  task automatic test_gnt_stall_reset();
    @(posedge clk); #1;
    start = 1'b1; opcode_e = LW; addr = 32'h40; store_data = 32'hFFFFFFFF;
    mem_rdata = 32'h99999999; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy_T got %0b exp 1", busy); end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_gnt = 1'b0;
      @(negedge clk);
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL stall_req_c%0d got %0b exp 1", c, mem_req); end
      vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL stall_addr_c%0d got %h exp 00000040", c, mem_addr); end
      vectors++; if (mem_be !== 4'hF) begin miscompares++; $display("FAIL stall_be_c%0d got %h exp f", c, mem_be); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL stall_we_c%0d got %0b exp 0", c, mem_we); end
      vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL stall_wdata_c%0d got %h exp 0", c, mem_wdata); end
    end
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL stall_req_gnt got %0b exp 1", mem_req); end
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL wait_req got %0b exp 0", mem_req); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wait_busy got %0b exp 1", busy); end
    // Asynchronous reset in WAIT, away from any clock edge.
    #1 rst_n = 1'b0;
    #1;
    exp_ld = 32'h0;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL arst_req got %0b exp 0", mem_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %0b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL arst_done got %0b exp 0", done); end
    vectors++; if (mem_be !== 4'h0) begin miscompares++; $display("FAIL arst_be got %h exp 0", mem_be); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL arst_addr got %h exp 0", mem_addr); end
    vectors++; if (load_data !== exp_ld) begin miscompares++; $display("FAIL arst_ld got %h exp %h", load_data, exp_ld); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL post_rst_done1 got %0b exp 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %0b exp 0", busy); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL post_rst_done2 got %0b exp 0", done); end
    run_access(LW, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
    exp_ld = 32'hCAFEF00D;
    vectors++; if (o_done_cyc !== 3) begin miscompares++; $display("FAIL post_rst_lw_done_cyc got %0d exp 3", o_done_cyc); end
    vectors++; if (o_addr !== 32'h40) begin miscompares++; $display("FAIL post_rst_lw_addr got %h exp 00000040", o_addr); end
    vectors++; if (o_ld !== exp_ld) begin miscompares++; $display("FAIL post_rst_lw_data got %h exp %h", o_ld, exp_ld); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_byte_loads();
    test_half_loads();
    test_sh();
    test_misaligned();
    test_ignored_opcode();
    test_rvalid_delay();
    test_gnt_stall_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_single_cycle.md
# lsu_single_cycle

Load/store unit for the RV32I single-cycle core, directly downstream of the ALU. It takes the ALU result as the effective address, plus rs2 data and the decoded opcode. It runs one data-memory transaction over a request/grant/response handshake, and stalls the core through `busy` until the access completes. It returns byte/half/word-extracted, sign- or zero-extended load data, and flags misaligned accesses without touching memory.

## Interface
- `DATA_WIDTH`, default 32: data path width. Only 32 is supported; byte-enable width is DATA_WIDTH/8.
- `ADDR_WIDTH`, default 32: address width.

- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  core presents a memory instruction this cycle. It is only sampled in IDLE.
- `opcode_e`  in  rv32i_base_instr  one of LB, LH, LW, LBU, LHU, SB, SH, SW. `start` with any other opcode is ignored.
- `addr`  in  ADDR_WIDTH  effective address (ALU result).
- `store_data`  in  DATA_WIDTH  rs2 value.
- `busy`  out  1  stall request to core.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  valid with `done`; access was rejected.
- `load_data`  out  DATA_WIDTH  extended load result. Updated only on a successful load `done`; held otherwise.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, equal to {addr[ADDR_WIDTH-1:2], 2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  DATA_WIDTH  write data, replicated lanes.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  response (loads and stores).
- `mem_rdata`  in  DATA_WIDTH  read word, valid with `mem_rvalid`.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - `start` with a memory opcode latches opcode_e, addr, store_data and the offset addr[1:0].
  - If the access is aligned, go to REQ.
  - If it is misaligned, go to RESP with `misaligned`=1.
- **Misaligned rules:**
  - LH, LHU or SH with addr[0]=1.
  - LW or SW with addr[1:0]≠0.
  - Byte accesses are never misaligned.
- **REQ:**
  - `mem_req`=1, and mem_we/mem_addr/mem_be/mem_wdata are driven from latched values.
  - All of these hold stable until `mem_gnt`=1, then go to WAIT.
- **WAIT:**
  - `mem_req`=0.
  - On `mem_rvalid`=1, capture the extracted load data if the access is a load, then go to RESP.
- **RESP:** `done`=1 for exactly one cycle, then go to IDLE.
- **busy** = (state≠IDLE && state≠RESP) || (state==IDLE && start && memory opcode). It is combinational, so the core stalls in the start cycle and advances on the `done` edge.
- **Byte enables** (o = latched offset):
  - SB/LB/LBU: 4'b0001<<o
  - SH/LH/LHU: 4'b0011<<o
  - SW/LW: 4'b1111
- **Write data:**
  - SB: {4{store_data[7:0]}}
  - SH: {2{store_data[15:0]}}
  - SW: store_data
  - Loads drive `mem_wdata`=0 and `mem_we`=0.
- **Load extraction:**
  - Byte = mem_rdata[8o+7:8o]; half = mem_rdata[8o+15:8o].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Signals outside their active state:** `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.

## Timing
- **Reset values:** state IDLE; busy, done, misaligned, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, load_data = 0.
- **Reset mid-operation:** aborts immediately. `mem_req` drops asynchronously, no `done` is issued, and a later `mem_rvalid` is ignored.
- **Aligned access, start at cycle T:**
  - `mem_req` is asserted in T+1.
  - With gnt at T+1 and rvalid at T+2, `done` is asserted at T+3.
  - Each cycle of gnt or rvalid delay adds one cycle.
- **Misaligned access:** `done`+`misaligned` at T+1, with no `mem_req` in any cycle.
- **Back-to-back:** a new `start` is accepted in the cycle after RESP (IDLE). Minimum spacing between accesses is 4 cycles.
- **load_data timing:** registered, valid from the `done` cycle onward.

## Test plan
- SW, addr 0x100, store_data 0xDEADBEEF, gnt at T+1, rvalid at T+2 -> T+1: mem_req=1, mem_we=1, mem_addr=0x100, mem_be=0xF, mem_wdata=0xDEADBEEF. T+3: done=1, misaligned=0, and load_data is unchanged.
- LB, addr 0x103, rdata 0x80FF0000 -> load_data=0xFFFFFF80, mem_be=0x8. Same access with LBU -> 0x00000080.
- LH, addr 0x102, rdata 0x80011234 -> load_data=0xFFFF8001, mem_be=0xC. Same access with LHU -> 0x00008001.
- SH, addr 0x202, store_data 0x1234ABCD -> mem_be=0xC, mem_wdata=0xABCDABCD, mem_addr=0x200.
- LW at 0x101, and separately SH at 0x203 -> done=1 and misaligned=1 at T+1, mem_req never asserted, busy high only in cycle T.
- LW at 0x40 with gnt withheld 3 cycles, request fields checked stable every cycle, then rst_n pulsed low in WAIT -> all outputs 0 immediately, subsequent mem_rvalid produces no done, and a new LW after reset completes normally.
